// File: rtl/subbytes_fwd_seq.sv
// subbytes_fwd_seq -- forward AES SubBytes, time-multiplexed over LANES S-boxes.
//
// A 128-bit state is latched on acceptance and fed through LANES byte lookups
// per cycle (BEATS = 16/LANES beats). Each lookup result is registered, then
// written into the output register one edge later. out_valid rises BEATS+1
// edges after the accepting edge and holds until out_ready is seen.
//
// Parameters:
//   LANES      S-box lookups per cycle: 1, 2, 4, 8 or 16
// Ports:
//   clk        clock, rising edge
//   rst_n      synchronous active-low reset
//   in_valid   in_data valid
//   in_ready   block can accept a state (IDLE and not in reset)
//   in_data    state; byte 0 = [127:120] ... byte 15 = [7:0]
//   inv        (SUBBYTES_FWD_DUAL_EN only) 1 = inverse table, latched with in_data
//   out_valid  out_data holds a complete result
//   out_ready  downstream accepts out_data
//   out_data   SubBytes(in_data), same byte order
// Build option:
//   SUBBYTES_FWD_DUAL_EN  adds the inv port and the inverse-table path.

// One byte lookup. The table is built from the GF(2^8) inverse plus the
// FIPS-197 affine map, so forward and inverse share the inverter.
module sbox_lane (
   input  logic [7:0] a,
`ifdef SUBBYTES_FWD_DUAL_EN
   input  logic       inv,
`endif
   output logic [7:0] y
);
   function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] z);
      logic [7:0] p, t;
      p = '0;
      t = x;
      for (int i = 0; i < 8; i++) begin
         if (z[i]) p = p ^ t;
         t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   // x^254 == x^-1 for x != 0, and 0 maps to 0.
   function automatic logic [7:0] ginv(input logic [7:0] x);
      logic [7:0] r, sq;
      r  = 8'h01;
      sq = x;
      for (int i = 1; i < 8; i++) begin
         sq = gmul(sq, sq);
         r  = gmul(r, sq);
      end
      return r;
   endfunction

   function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
      return (x << n) | (x >> (8 - n));
   endfunction

   function automatic logic [7:0] fwd(input logic [7:0] x);
      logic [7:0] v;
      v = ginv(x);
      return v ^ rotl(v, 1) ^ rotl(v, 2) ^ rotl(v, 3) ^ rotl(v, 4) ^ 8'h63;
   endfunction

`ifdef SUBBYTES_FWD_DUAL_EN
   function automatic logic [7:0] bwd(input logic [7:0] x);
      return ginv(rotl(x, 1) ^ rotl(x, 3) ^ rotl(x, 6) ^ 8'h05);
   endfunction

   assign y = inv ? bwd(a) : fwd(a);
`else
   assign y = fwd(a);
`endif
endmodule

module subbytes_fwd_seq #(
   parameter int LANES = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] in_data,
`ifdef SUBBYTES_FWD_DUAL_EN
   input  logic         inv,
`endif
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out_data
);
   localparam int BEATS = 16 / LANES;
   localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

   generate
      if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
         $error("subbytes_fwd_seq: LANES must be 1, 2, 4, 8 or 16");
      end
   endgenerate

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t state, nstate;

   // Ascending packed range so element 0 is the most significant byte.
   logic [0:15][7:0]           data_q, out_q;
   logic [LANES-1:0][7:0]      lane_in, lane_out, sbox_q;
   logic [CW-1:0]              cnt, cap_beat;
   logic [3:0]                 base, cap_base;
   // [0]: a beat is presented to the S-boxes; [1]: sbox_q holds a beat to write.
   logic [1:0]                 vld_pipe;
   logic                       accept;
`ifdef SUBBYTES_FWD_DUAL_EN
   logic                       inv_q;
`endif

   assign in_ready = rst_n && (state == IDLE);
   assign accept   = (state == IDLE) && in_valid;
   assign base     = 4'(int'(cnt) * LANES);
   assign cap_base = 4'(int'(cap_beat) * LANES);
   assign out_data = out_q;

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      assign lane_in[i] = data_q[base + 4'(i)];
      sbox_lane u_sbox (
         .a   (lane_in[i]),
`ifdef SUBBYTES_FWD_DUAL_EN
         .inv (inv_q),
`endif
         .y   (lane_out[i])
      );
   end

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= nstate;
   end

   always_comb begin
      nstate = state;
      case (state)
         IDLE:    if (in_valid) nstate = RUN;
         RUN:     if (vld_pipe[1] && cap_beat == LAST) nstate = DONE;
         DONE:    if (out_ready) nstate = IDLE;
         default: nstate = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         data_q    <= '0;
         out_q     <= '0;
         sbox_q    <= '0;
         cnt       <= '0;
         cap_beat  <= '0;
         vld_pipe  <= '0;
         out_valid <= 1'b0;
`ifdef SUBBYTES_FWD_DUAL_EN
         inv_q     <= 1'b0;
`endif
      end else begin
         if (accept) begin
            data_q      <= in_data;
            vld_pipe[0] <= 1'b1;
            cnt         <= '0;
`ifdef SUBBYTES_FWD_DUAL_EN
            inv_q       <= inv;
`endif
         end
         vld_pipe[1] <= vld_pipe[0];
         if (vld_pipe[0]) begin
            sbox_q   <= lane_out;
            cap_beat <= cnt;
            if (cnt == LAST) begin
               cnt         <= '0;
               vld_pipe[0] <= 1'b0;
            end else begin
               cnt <= cnt + 1'b1;
            end
         end
         if (vld_pipe[1]) begin
            for (int i = 0; i < LANES; i++) out_q[cap_base + 4'(i)] <= sbox_q[i];
            if (cap_beat == LAST) out_valid <= 1'b1;
         end
         if (state == DONE && out_ready) out_valid <= 1'b0;
      end
   end
endmodule

// File: tb/tb_subbytes_fwd_seq.sv
// Scoreboard bench for subbytes_fwd_seq (LANES=4). Expected results are
// published FIPS-197 S-box values pushed at acceptance; a negedge monitor
// pops and compares on every output handshake and checks the latency.
module tb_subbytes_fwd_seq;
   localparam int LANES = 4;
   localparam int BEATS = 16 / LANES;

   logic         clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
   logic [127:0] in_data = '0;
   logic         in_ready, out_valid;
   logic [127:0] out_data;
`ifdef SUBBYTES_FWD_DUAL_EN
   logic         inv = 1'b0;
`endif

   subbytes_fwd_seq #(.LANES(LANES)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
`ifdef SUBBYTES_FWD_DUAL_EN
      .inv       (inv),
`endif
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data)
   );

   always #5 clk = ~clk;

   int checks = 0, errors = 0, cyc = 0, acc_cyc = 0;
   logic [127:0] exp_q[$];
   logic prev_ov = 1'b0;

   localparam logic [127:0] Z_IN  = 128'h0;
   localparam logic [127:0] Z_OUT = 128'h63636363_63636363_63636363_63636363;
   localparam logic [127:0] A_IN  = 128'h00112233_44556677_8899aabb_ccddeeff;
   localparam logic [127:0] A_OUT = 128'h638293c3_1bfc33f5_c4eeacea_4bc12816;
   localparam logic [127:0] B_IN  = 128'h193de3be_a0f4e22b_9ac68d2a_e9f84808;
   localparam logic [127:0] B_OUT = 128'hd42711ae_e0bf98f1_b8b45de5_1e415230;
   localparam logic [127:0] F_IN  = {16{8'hff}};
   localparam logic [127:0] F_OUT = {16{8'h16}};
   localparam logic [127:0] S_IN  = {16{8'h53}};
   localparam logic [127:0] S_OUT = {16{8'hed}};

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   // Monitor: latency on the out_valid rising edge, data on each handshake.
   always @(negedge clk) begin
      if (rst_n) begin
         if (out_valid && !prev_ov) check("latency", 128'(cyc - acc_cyc), 128'(BEATS + 1));
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_output: got %h expected none", out_data);
            end else begin
               check("out_data", out_data, exp_q.pop_front());
            end
         end
      end
      prev_ov = out_valid;
   end

   // Called #1 after a posedge; returns #1 after the accepting posedge.
   task automatic send(input logic [127:0] d, input logic [127:0] e, input bit push, output int waited);
      waited = 0;
      in_valid = 1'b1;
      in_data  = d;
      forever begin
         @(negedge clk);
         if (in_ready) break;
         waited++;
         if (waited > 200) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got no in_ready expected in_ready within 200 cycles");
            @(posedge clk);
            #1 in_valid = 1'b0;
            return;
         end
      end
      @(posedge clk);
      #1;
      acc_cyc = cyc;
      if (push) exp_q.push_back(e);
      in_valid = 1'b0;
      in_data  = {$urandom(), $urandom(), $urandom(), $urandom()};
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         @(posedge clk);
         n++;
      end
      #1;
      check("drain", 128'(exp_q.size()), 128'h0);
   endtask

   initial begin
      int w;
      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_in_ready", 128'(in_ready), 128'h0);
      check("rst_out_valid", 128'(out_valid), 128'h0);
      check("rst_out_data", out_data, 128'h0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      check("in_ready_after_rst", 128'(in_ready), 128'h1);
      @(posedge clk);
      #1;

      // Basic vectors, back to back
      send(Z_IN, Z_OUT, 1'b1, w);
      send(A_IN, A_OUT, 1'b1, w);
      send(B_IN, B_OUT, 1'b1, w);
      send(F_IN, F_OUT, 1'b1, w);
      drain();

      // Backpressure: output held while new data waits upstream
      out_ready = 1'b0;
      send(S_IN, S_OUT, 1'b1, w);
      w = 0;
      while (!out_valid && w < 50) begin
         @(negedge clk);
         w++;
      end
      check("bp_valid_rise", 128'(out_valid), 128'h1);
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         in_valid = 1'b1;
         in_data  = {$urandom(), $urandom(), $urandom(), $urandom()};
         @(negedge clk);
         check("bp_out_valid", 128'(out_valid), 128'h1);
         check("bp_out_data", out_data, S_OUT);
         check("bp_in_ready", 128'(in_ready), 128'h0);
      end
      @(posedge clk);
      #1 out_ready = 1'b1;
      send(A_IN, A_OUT, 1'b1, w);
      check("accept_after_done", 128'(w), 128'h1);
      drain();

      // Reset in the third RUN cycle discards the state in flight
      send(B_IN, B_OUT, 1'b0, w);
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("midrst_out_valid", 128'(out_valid), 128'h0);
      check("midrst_out_data", out_data, 128'h0);
      check("midrst_in_ready", 128'(in_ready), 128'h0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (10) @(negedge clk);
      check("midrst_no_output", 128'(out_valid), 128'h0);
      @(posedge clk);
      #1;
      send(B_IN, B_OUT, 1'b1, w);
      drain();

`ifdef SUBBYTES_FWD_DUAL_EN
      inv = 1'b1;
      send(A_OUT, A_IN, 1'b1, w);
      send(Z_OUT, Z_IN, 1'b1, w);
      inv = 1'b0;
      send(A_IN, A_OUT, 1'b1, w);
      drain();
`endif

      repeat (3) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish expected finish before 200000");
      $fatal(1, "timeout");
   end
endmodule
